// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: sequential fetch from a 1-cycle inst SRAM into a small
// FIFO, presented to ID with valid/allow-in; handles redirect, stall and ADEF tagging.
module if_fetch_queue #(
    parameter int unsigned FQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        br_stall,
    input  logic        id_allow_in,
    output logic        inst_sram_en,
    output logic [3:0]  inst_sram_we,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    output logic        if_to_id_valid,
    output logic [31:0] if_to_id_pc,
    output logic [31:0] if_to_id_inst,
    output logic        if_to_id_adef
);
    localparam int unsigned PW = $clog2(FQ_DEPTH);
    localparam int unsigned CW = PW + 1;

    // Handshake: an entry transfers to ID in any cycle where if_to_id_valid and
    // id_allow_in are both high; a redirect cycle never transfers.

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic          inflight_q, inflight_d;
    logic          halted_q, halted_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0] fq_pc_q   [FQ_DEPTH];
    logic [31:0] fq_inst_q [FQ_DEPTH];
    logic        fq_adef_q [FQ_DEPTH];

    logic          bypass_hit, out_valid, pop, pop_q_entry, issue;
    logic          push, push_adef;
    logic [PW-1:0] push_idx;
    logic [31:0]   push_pc, push_inst;
    logic [31:0]   out_pc, out_inst;
    logic          out_adef;
    logic [CW:0]   credit;

    always_comb begin
        bypass_hit = BYPASS && (count_q == '0) && inflight_q && !br_taken;
        out_valid  = !reset && !br_taken && ((count_q != '0) || bypass_hit);

        if (count_q != '0) begin
            out_pc   = fq_pc_q[head_q];
            out_inst = fq_inst_q[head_q];
            out_adef = fq_adef_q[head_q];
        end else begin
            out_pc   = req_pc_q;
            out_inst = inst_sram_rdata;
            out_adef = 1'b0;
        end

        pop         = out_valid && id_allow_in;
        pop_q_entry = pop && (count_q != '0);
        // Slots already committed after this cycle: queued + returning - leaving.
        credit = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
        issue  = !reset && !br_stall && !halted_q && (credit < (CW+1)'(FQ_DEPTH));
    end

    always_comb begin
        fetch_pc_d     = fetch_pc_q;
        req_pc_d       = req_pc_q;
        inflight_d     = 1'b0;
        halted_d       = halted_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        push           = 1'b0;
        push_idx       = tail_q;
        push_pc        = req_pc_q;
        push_inst      = inst_sram_rdata;
        push_adef      = 1'b0;
        inst_sram_en   = 1'b0;
        inst_sram_addr = fetch_pc_q;

        if (reset) begin
            fetch_pc_d     = RESET_PC;
            halted_d       = 1'b0;
            head_d         = '0;
            tail_d         = '0;
            count_d        = '0;
            inst_sram_addr = '0;
        end else if (br_taken) begin
            // Flush everything, including the response returning this cycle.
            halted_d = 1'b0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
            if (br_target[1:0] == 2'b00) begin
                inst_sram_en   = 1'b1;
                inst_sram_addr = br_target;
                fetch_pc_d     = br_target + 32'd4;
                inflight_d     = 1'b1;
                req_pc_d       = br_target;
            end else begin
                push      = 1'b1;
                push_idx  = '0;
                push_pc   = br_target;
                push_inst = '0;
                push_adef = 1'b1;
                tail_d    = PW'(1);
                count_d   = CW'(1);
                halted_d  = 1'b1;
            end
        end else begin
            if (issue) begin
                inst_sram_en = 1'b1;
                fetch_pc_d   = fetch_pc_q + 32'd4;
                inflight_d   = 1'b1;
                req_pc_d     = fetch_pc_q;
            end
            push = inflight_q && !(bypass_hit && id_allow_in);
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            if (pop_q_entry) begin
                head_d = head_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop_q_entry);
        end
    end

    always_ff @(posedge clk) begin
        fetch_pc_q <= fetch_pc_d;
        req_pc_q   <= req_pc_d;
        inflight_q <= inflight_d;
        halted_q   <= halted_d;
        head_q     <= head_d;
        tail_q     <= tail_d;
        count_q    <= count_d;
        if (push) begin
            fq_pc_q[push_idx]   <= push_pc;
            fq_inst_q[push_idx] <= push_inst;
            fq_adef_q[push_idx] <= push_adef;
        end
    end

    assign inst_sram_we    = 4'b0000;
    assign inst_sram_wdata = 32'h0;
    assign if_to_id_valid  = out_valid;
    assign if_to_id_pc     = out_valid ? out_pc   : 32'h0;
    assign if_to_id_inst   = out_valid ? out_inst : 32'h0;
    assign if_to_id_adef   = out_valid && out_adef;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: BYPASS=1 (dut 0) and BYPASS=0 (dut 1) share stimulus and
// are each compared every cycle against a queue-based reference model.
module tb_if_fetch_queue;
    localparam logic [31:0] RPC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset, br_taken, br_stall, id_allow_in;
    logic [31:0] br_target;

    logic        en    [2];
    logic [3:0]  we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        valid [2];
    logic [31:0] pc    [2];
    logic [31:0] inst  [2];
    logic        adef  [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_fetch_queue #(.FQ_DEPTH(4), .RESET_PC(RPC), .BYPASS(1'b1)) dut0 (
        .clk(clk), .reset(reset), .br_taken(br_taken), .br_target(br_target),
        .br_stall(br_stall), .id_allow_in(id_allow_in),
        .inst_sram_en(en[0]), .inst_sram_we(we[0]), .inst_sram_addr(addr[0]),
        .inst_sram_wdata(wdata[0]), .inst_sram_rdata(rdata[0]),
        .if_to_id_valid(valid[0]), .if_to_id_pc(pc[0]), .if_to_id_inst(inst[0]),
        .if_to_id_adef(adef[0])
    );

    if_fetch_queue #(.FQ_DEPTH(4), .RESET_PC(RPC), .BYPASS(1'b0)) dut1 (
        .clk(clk), .reset(reset), .br_taken(br_taken), .br_target(br_target),
        .br_stall(br_stall), .id_allow_in(id_allow_in),
        .inst_sram_en(en[1]), .inst_sram_we(we[1]), .inst_sram_addr(addr[1]),
        .inst_sram_wdata(wdata[1]), .inst_sram_rdata(rdata[1]),
        .if_to_id_valid(valid[1]), .if_to_id_pc(pc[1]), .if_to_id_inst(inst[1]),
        .if_to_id_adef(adef[1])
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
    endfunction

    // SRAM stand-ins: 1-cycle latency, junk when not enabled.
    always @(posedge clk) begin
        rdata[0] <= en[0] ? inst_of(addr[0]) : $urandom;
        rdata[1] <= en[1] ? inst_of(addr[1]) : $urandom;
    end

    // Observed vector: {valid, pc, inst, adef, en, addr-if-en}
    logic [98:0] obs [2];
    always_comb begin
        for (int d = 0; d < 2; d++)
            obs[d] = {valid[d], pc[d], inst[d], adef[d], en[d], en[d] ? addr[d] : 32'h0};
    end

    // Reference model: entries are {adef, pc, inst}
    logic [64:0] mq0[$];
    logic [64:0] mq1[$];
    logic        m_pend [2];
    logic [31:0] m_ppc  [2];
    logic [31:0] m_fpc  [2];
    logic        m_halt [2];
    logic [98:0] exp_obs [2];
    logic        exp_pop [2];
    logic        exp_en  [2];

    task automatic model_eval();
        int sz;
        logic [64:0] hd;
        logic v, p, e;
        logic [31:0] a;
        for (int d = 0; d < 2; d++) begin
            sz = (d == 0) ? mq0.size() : mq1.size();
            if (sz > 0) hd = (d == 0) ? mq0[0] : mq1[0];
            else        hd = {1'b0, m_ppc[d], inst_of(m_ppc[d])};
            v = !reset && !br_taken && (sz > 0 || (d == 0 && m_pend[d]));
            p = v && id_allow_in;
            if (reset) begin
                e = 1'b0; a = 32'h0;
            end else if (br_taken) begin
                e = (br_target[1:0] == 2'b00); a = br_target;
            end else begin
                e = !br_stall && !m_halt[d] && (sz + int'(m_pend[d]) - int'(p) < 4);
                a = m_fpc[d];
            end
            exp_pop[d] = p;
            exp_en[d]  = e;
            exp_obs[d] = {v, v ? hd[63:32] : 32'h0, v ? hd[31:0] : 32'h0, v && hd[64],
                          e, e ? a : 32'h0};
        end
    endtask

    task automatic model_update();
        logic [64:0] q[$];
        logic consumed;
        for (int d = 0; d < 2; d++) begin
            if (d == 0) q = mq0; else q = mq1;
            if (reset) begin
                q.delete();
                m_pend[d] = 1'b0; m_fpc[d] = RPC; m_halt[d] = 1'b0;
            end else if (br_taken) begin
                q.delete();
                if (br_target[1:0] == 2'b00) begin
                    m_pend[d] = 1'b1; m_ppc[d] = br_target;
                    m_fpc[d] = br_target + 32'd4; m_halt[d] = 1'b0;
                end else begin
                    m_pend[d] = 1'b0; m_halt[d] = 1'b1;
                    q.push_back({1'b1, br_target, 32'h0});
                end
            end else begin
                consumed = 1'b0;
                if (exp_pop[d]) begin
                    if (q.size() > 0) void'(q.pop_front());
                    else consumed = 1'b1;
                end
                if (m_pend[d] && !consumed) q.push_back({1'b0, m_ppc[d], inst_of(m_ppc[d])});
                m_pend[d] = exp_en[d];
                if (exp_en[d]) begin
                    m_ppc[d] = m_fpc[d];
                    m_fpc[d] = m_fpc[d] + 32'd4;
                end
            end
            if (d == 0) mq0 = q; else mq1 = q;
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input logic br, input logic [31:0] tgt, input logic stall, input logic allow);
        br_taken = br; br_target = tgt; br_stall = stall; id_allow_in = allow;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) begin settle(); advance(); end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            settle();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (obs[d] !== 99'h0 || we[d] !== 4'h0 || wdata[d] !== 32'h0) begin
                    n_err++;
                    $display("FAIL reset dut%0d c%0d got %h we %h wdata %h exp 0", d, c, obs[d], we[d], wdata[d]);
                end
            end
            advance();
        end
        reset = 1'b0;
    endtask

    task automatic test_stream();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        for (int c = 0; c < 8; c++) begin
            settle();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (obs[d] !== exp_obs[d]) begin
                    n_err++;
                    $display("FAIL stream dut%0d c%0d got %h exp %h", d, c, obs[d], exp_obs[d]);
                end
            end
            if (c == 0) begin
                n_vec++;
                if (!(en[0] && addr[0] === RPC) || valid[0] !== 1'b0) begin
                    n_err++;
                    $display("FAIL first_issue en %b addr %h valid %b exp en 1 addr %h valid 0", en[0], addr[0], valid[0], RPC);
                end
            end
            if (c == 1) begin
                n_vec++;
                if (valid[0] !== 1'b1 || pc[0] !== RPC || valid[1] !== 1'b0) begin
                    n_err++;
                    $display("FAIL bypass_lat v0 %b pc0 %h v1 %b exp 1 %h 0", valid[0], pc[0], valid[1], RPC);
                end
            end
            if (c == 2) begin
                n_vec++;
                if (valid[1] !== 1'b1 || pc[1] !== RPC || pc[0] !== RPC + 32'd4) begin
                    n_err++;
                    $display("FAIL nobypass_lat v1 %b pc1 %h pc0 %h exp 1 %h %h", valid[1], pc[1], pc[0], RPC, RPC + 32'd4);
                end
            end
            advance();
        end
    endtask

    task automatic test_full_queue();
        int issues [2];
        logic [31:0] resume_addr [2];
        logic seen [2];
        do_reset();
        issues = '{0, 0};
        seen = '{1'b0, 1'b0};
        resume_addr = '{32'h0, 32'h0};
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int c = 0; c < 20; c++) begin
            if (c == 10) id_allow_in = 1'b1;
            settle();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (obs[d] !== exp_obs[d]) begin
                    n_err++;
                    $display("FAIL full dut%0d c%0d got %h exp %h", d, c, obs[d], exp_obs[d]);
                end
                if (c < 10 && en[d]) issues[d]++;
                if (c >= 10 && en[d] && !seen[d]) begin seen[d] = 1'b1; resume_addr[d] = addr[d]; end
            end
            advance();
        end
        for (int d = 0; d < 2; d++) begin
            n_vec++;
            if (issues[d] !== 4 || resume_addr[d] !== RPC + 32'h10) begin
                n_err++;
                $display("FAIL full_credit dut%0d issues %0d resume %h exp 4 %h", d, issues[d], resume_addr[d], RPC + 32'h10);
            end
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c < 3)       drive(1'b0, 32'h0, 1'b0, 1'b0);
            else if (c == 3) drive(1'b1, RPC + 32'h100, 1'b1, 1'b1);
            else             drive(1'b0, 32'h0, 1'b0, 1'b1);
            settle();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (obs[d] !== exp_obs[d]) begin
                    n_err++;
                    $display("FAIL redirect dut%0d c%0d got %h exp %h", d, c, obs[d], exp_obs[d]);
                end
            end
            if (c == 3) begin
                n_vec++;
                if (valid[0] !== 1'b0 || !en[0] || addr[0] !== RPC + 32'h100) begin
                    n_err++;
                    $display("FAIL redirect_cycle valid %b en %b addr %h exp 0 1 %h", valid[0], en[0], addr[0], RPC + 32'h100);
                end
            end
            if (c == 4) begin
                n_vec++;
                if (valid[0] !== 1'b1 || pc[0] !== RPC + 32'h100) begin
                    n_err++;
                    $display("FAIL redirect_first valid %b pc %h exp 1 %h", valid[0], pc[0], RPC + 32'h100);
                end
            end
            advance();
        end
    endtask

    task automatic test_adef();
        int stray;
        stray = 0;
        for (int c = 0; c < 16; c++) begin
            if (c == 0)       drive(1'b1, RPC + 32'h102, 1'b0, 1'b0);
            else if (c == 10) drive(1'b1, RPC + 32'h200, 1'b0, 1'b1);
            else if (c < 10)  drive(1'b0, 32'h0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else              drive(1'b0, 32'h0, 1'b0, 1'b1);
            settle();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (obs[d] !== exp_obs[d]) begin
                    n_err++;
                    $display("FAIL adef dut%0d c%0d got %h exp %h", d, c, obs[d], exp_obs[d]);
                end
                if (c < 10 && en[d]) stray++;
                if (c == 1) begin
                    n_vec++;
                    if ({valid[d], adef[d], pc[d], inst[d]} !== {1'b1, 1'b1, RPC + 32'h102, 32'h0}) begin
                        n_err++;
                        $display("FAIL adef_entry dut%0d v %b adef %b pc %h inst %h exp 1 1 %h 0", d, valid[d], adef[d], pc[d], inst[d], RPC + 32'h102);
                    end
                end
                if (c == 10) begin
                    n_vec++;
                    if (!en[d] || addr[d] !== RPC + 32'h200) begin
                        n_err++;
                        $display("FAIL adef_resume dut%0d en %b addr %h exp 1 %h", d, en[d], addr[d], RPC + 32'h200);
                    end
                end
            end
            advance();
        end
        n_vec++;
        if (stray !== 0) begin
            n_err++;
            $display("FAIL adef_halt stray issues %0d exp 0", stray);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, 32'h0, (c >= 3 && c < 6), 1'b1);
            settle();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (obs[d] !== exp_obs[d]) begin
                    n_err++;
                    $display("FAIL stall dut%0d c%0d got %h exp %h", d, c, obs[d], exp_obs[d]);
                end
                if (c >= 3 && c < 6 && en[d] !== 1'b0) begin
                    n_vec++; n_err++;
                    $display("FAIL stall_issue dut%0d c%0d en %b exp 0", d, c, en[d]);
                end
                if (c == 6) begin
                    n_vec++;
                    if (!en[d] || addr[d] !== RPC + 32'hc) begin
                        n_err++;
                        $display("FAIL stall_resume dut%0d en %b addr %h exp 1 %h", d, en[d], addr[d], RPC + 32'hc);
                    end
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tgt = RPC + (32'($urandom_range(0, 255)) << 2);
            if ($urandom_range(0, 3) == 0) tgt = tgt + 32'($urandom_range(1, 3));
            reset = ($urandom_range(0, 99) == 0);
            drive(($urandom_range(0, 11) == 0), tgt, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) != 0));
            settle();
            for (int d = 0; d < 2; d++) begin
                n_vec++;
                if (obs[d] !== exp_obs[d]) begin
                    n_err++;
                    $display("FAIL random dut%0d c%0d got %h exp %h", d, c, obs[d], exp_obs[d]);
                end
            end
            advance();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            m_pend[d] = 1'b0; m_ppc[d] = RPC; m_fpc[d] = RPC; m_halt[d] = 1'b0;
        end
        test_reset();
        test_stream();
        test_full_queue();
        test_redirect();
        test_adef();
        test_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
